// File: rtl/sdft_pkg.sv
// Shared widths, complex bin type and elaboration-time helpers for the sliding DFT.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sdft_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int FREQ_BINS     = 16;
  localparam int TWIDDLE_WIDTH = 8;
  localparam int BIN_WIDTH     = 16;
  localparam int OUT_WIDTH     = 16;
  localparam int TW_SHIFT      = TWIDDLE_WIDTH - 2;

  // One complex bin at the default bin width.
  typedef struct packed {
    logic signed [BIN_WIDTH-1:0] re;
    logic signed [BIN_WIDTH-1:0] im;
  } cplx_t;

  // Fixed-point angle scale used while building the twiddle table.
  localparam longint ANGLE_ONE   = 64'sd1 << 30;
  localparam longint PI_HALF_Q30 = 64'sd1686629713;

  // Smallest r with 2^r >= v; sizes the circular-buffer pointer.
  function automatic int sdft_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // round(2^shift * cos/sin(2*pi*k/n)) using integer Taylor series on the
  // first quadrant and symmetry for the rest, so quadrant points are exact.
  function automatic int sdft_twiddle(input int k, input int n, input int shift,
                                      input bit want_sin);
    int     q;
    int     r;
    longint x;
    longint term;
    longint c;
    longint s;
    longint v;
    longint m;
    q    = (4 * k) / n;
    r    = 4 * k - q * n;
    x    = (PI_HALF_Q30 * longint'(r)) / longint'(n);
    term = ANGLE_ONE;
    c    = 64'sd0;
    s    = 64'sd0;
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0:       c = c + term;
        1:       s = s + term;
        2:       c = c - term;
        default: s = s - term;
      endcase
      term = (term * x) / ANGLE_ONE / longint'(i + 1);
    end
    case (q)
      0:       v = want_sin ? s  : c;
      1:       v = want_sin ? c  : -s;
      2:       v = want_sin ? -s : -c;
      default: v = want_sin ? -c : s;
    endcase
    m = (v < 64'sd0) ? -v : v;
    m = ((m << shift) + (ANGLE_ONE >>> 1)) >>> 30;
    return (v < 64'sd0) ? -int'(m) : int'(m);
  endfunction

endpackage

// File: rtl/sdft_twiddle_rom.sv
// Read-only table of W_k = e^(+j*2*pi*k/N) in Q2.(twiddle_width-2), all N entries in parallel.
// Latency: combinational, constant after elaboration.
// Backpressure: none.
module sdft_twiddle_rom
  import sdft_pkg::*;
#(
  parameter int n             = FREQ_BINS,
  parameter int twiddle_width = TWIDDLE_WIDTH
) (
  output logic signed [twiddle_width-1:0] twr [n],
  output logic signed [twiddle_width-1:0] twi [n]
);

  for (genvar k = 0; k < n; k++) begin : g_entry
    localparam int RE_VAL = sdft_twiddle(k, n, twiddle_width - 2, 1'b0);
    localparam int IM_VAL = sdft_twiddle(k, n, twiddle_width - 2, 1'b1);
    assign twr[k] = twiddle_width'(RE_VAL);
    assign twi[k] = twiddle_width'(IM_VAL);
  end

endmodule

// File: rtl/sliding_dft.sv
// Streaming sliding DFT: one sample per clk, all N complex bins updated every edge; bins 0/1 on freqs_0/freqs_1.
// Latency: sample before edge t is visible on bins and freqs_* right after edge t (outputs combinational).
// Backpressure: none, a sample is consumed every edge. SDFT_MAG_EN selects L1 magnitude outputs instead of raw real parts.
module sliding_dft
  import sdft_pkg::*;
#(
  parameter int data_width    = DATA_WIDTH,
  parameter int freq_bins     = FREQ_BINS,
  parameter int twiddle_width = TWIDDLE_WIDTH,
  parameter int bin_width     = BIN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] sample,
  output logic [OUT_WIDTH-1:0]  freqs_0,
  output logic [OUT_WIDTH-1:0]  freqs_1
);

  localparam int PTR_W = sdft_clog2(freq_bins);
  localparam int SHIFT = twiddle_width - 2;
  localparam int PW    = bin_width + twiddle_width + 2;

  logic signed [data_width-1:0]    samples             [freq_bins];
  logic        [PTR_W-1:0]         ptr;
  logic signed [bin_width-1:0]     frequency_bins_real [freq_bins];
  logic signed [bin_width-1:0]     frequency_bins_imag [freq_bins];
  logic signed [bin_width-1:0]     next_real           [freq_bins];
  logic signed [bin_width-1:0]     next_imag           [freq_bins];
  logic signed [twiddle_width-1:0] twiddle_rom_real    [freq_bins];
  logic signed [twiddle_width-1:0] twiddle_rom_imag    [freq_bins];
  logic signed [data_width:0]      delta;

  sdft_twiddle_rom #(
    .n             (freq_bins),
    .twiddle_width (twiddle_width)
  ) u_twiddle_rom (
    .twr (twiddle_rom_real),
    .twi (twiddle_rom_imag)
  );

  // New sample enters, the one from N cycles ago leaves; both feed every bin.
  assign delta = (data_width+1)'($signed(sample)) - (data_width+1)'(samples[ptr]);

  // Circular history buffer: overwrite the oldest slot, pointer wraps mod N.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < freq_bins; i++) samples[i] <= '0;
      ptr <= '0;
    end else begin
      samples[ptr] <= $signed(sample);
      ptr          <= ptr + PTR_W'(1);
    end
  end

  // One complex multiply-update lane per bin: X_k <= (X_k + delta) * W_k.
  for (genvar k = 0; k < freq_bins; k++) begin : g_lane
    logic signed [bin_width:0] a;
    logic signed [bin_width:0] b;
    logic signed [PW-1:0]      prod_re;
    logic signed [PW-1:0]      prod_im;

    assign a = (bin_width+1)'(frequency_bins_real[k]) + (bin_width+1)'(delta);
    assign b = (bin_width+1)'(frequency_bins_imag[k]);

    assign prod_re = PW'(a) * PW'(twiddle_rom_real[k]) - PW'(b) * PW'(twiddle_rom_imag[k]);
    assign prod_im = PW'(a) * PW'(twiddle_rom_imag[k]) + PW'(b) * PW'(twiddle_rom_real[k]);

    // Floor shift back to bin scale, then wrap; no saturation so bin 0 stays an exact sum.
    assign next_real[k] = bin_width'(prod_re >>> SHIFT);
    assign next_imag[k] = bin_width'(prod_im >>> SHIFT);
  end

  // Bin registers, all lanes committed together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < freq_bins; i++) begin
        frequency_bins_real[i] <= '0;
        frequency_bins_imag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < freq_bins; i++) begin
        frequency_bins_real[i] <= next_real[i];
        frequency_bins_imag[i] <= next_imag[i];
      end
    end
  end

`ifdef SDFT_MAG_EN
  localparam int SW = bin_width + 2;

  // |re| + |im|, unsigned, clamped to the all-ones output code.
  function automatic logic [OUT_WIDTH-1:0] l1_mag(input logic signed [bin_width-1:0] re,
                                                  input logic signed [bin_width-1:0] im);
    logic signed [bin_width:0] re_x;
    logic signed [bin_width:0] im_x;
    logic        [bin_width:0] ar;
    logic        [bin_width:0] ai;
    logic        [SW-1:0]      sum;
    re_x = (bin_width+1)'(re);
    im_x = (bin_width+1)'(im);
    ar   = $unsigned((re_x < 0) ? -re_x : re_x);
    ai   = $unsigned((im_x < 0) ? -im_x : im_x);
    sum  = SW'(ar) + SW'(ai);
    if (sum > SW'({OUT_WIDTH{1'b1}})) return {OUT_WIDTH{1'b1}};
    return OUT_WIDTH'(sum);
  endfunction

  // Magnitude view of bins 0 and 1.
  always_comb begin
    freqs_0 = l1_mag(frequency_bins_real[0], frequency_bins_imag[0]);
    freqs_1 = l1_mag(frequency_bins_real[1], frequency_bins_imag[1]);
  end
`else
  // Raw signed real parts of bins 0 and 1.
  always_comb begin
    freqs_0 = OUT_WIDTH'(frequency_bins_real[0]);
    freqs_1 = OUT_WIDTH'(frequency_bins_real[1]);
  end
`endif

endmodule

// File: tb/tb_sliding_dft.sv
// Directed bench for sliding_dft: reset, twiddle table, DC, alternating, tone, wrap and async reset.
// Latency: each step drives one sample and checks #1 after the edge that consumed it.
// Backpressure: none.
module tb_sliding_dft;
  import sdft_pkg::*;

  // Bin 1 twiddle: round(64*cos(22.5 deg)), round(64*sin(22.5 deg)).
  localparam int W1R = 59;
  localparam int W1I = 24;

  logic        clk;
  logic        reset;
  logic [7:0]  sample;
  logic [15:0] freqs_0;
  logic [15:0] freqs_1;

  int checks;
  int failures;

  int    hist [16];
  int    mptr;
  cplx_t b0;
  cplx_t b1;
  cplx_t b8;
  int    cos_tab [16];
  int    tone    [16];

  sliding_dft dut (
    .clk     (clk),
    .reset   (reset),
    .sample  (sample),
    .freqs_0 (freqs_0),
    .freqs_1 (freqs_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int port_val(input cplx_t c);
`ifdef SDFT_MAG_EN
    int m;
    m = ((c.re < 0) ? -int'(c.re) : int'(c.re)) + ((c.im < 0) ? -int'(c.im) : int'(c.im));
    return (m > 65535) ? 65535 : m;
`else
    return int'(c.re);
`endif
  endfunction

  function automatic int obs_port(input logic [15:0] f);
`ifdef SDFT_MAG_EN
    return int'(f);
`else
    return int'($signed(f));
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) hist[i] = 0;
    mptr = 0;
    b0   = '0;
    b1   = '0;
    b8   = '0;
  endtask

  // Reference recurrence for bins 0, 1 and 8 with the hand-derived twiddles.
  task automatic model_step(input int s);
    int d;
    int a;
    int b;
    d = s - hist[mptr];
    hist[mptr] = s;
    mptr = (mptr + 1) % 16;
    b0.re = 16'(int'(b0.re) + d);
    a = int'(b1.re) + d;
    b = int'(b1.im);
    b1.re = 16'((a * W1R - b * W1I) >>> 6);
    b1.im = 16'((a * W1I + b * W1R) >>> 6);
    a = int'(b8.re) + d;
    b = int'(b8.im);
    b8.re = 16'((a * -64) >>> 6);
    b8.im = 16'((b * -64) >>> 6);
  endtask

  task automatic step(input int s);
    sample = 8'(s);
    @(posedge clk);
    #1;
    model_step(s);
    check("model_f0", obs_port(freqs_0), port_val(b0));
    check("model_f1", obs_port(freqs_1), port_val(b1));
    check("model_bin8_re", int'(dut.frequency_bins_real[8]), int'(b8.re));
  endtask

  initial begin
    int v;
    checks   = 0;
    failures = 0;
    cos_tab  = '{64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24, 0, 24, 45, 59};
    tone     = '{100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38, 0, 38, 71, 92};
    model_reset();

    // Reset held low for three edges with a live sample.
    reset  = 1'b0;
    sample = 8'd10;
    repeat (3) @(posedge clk);
    #1;
    check("reset_f0", obs_port(freqs_0), 0);
    check("reset_f1", obs_port(freqs_1), 0);
    check("reset_bin8", int'(dut.frequency_bins_real[8]), 0);

    // Twiddle table against hand-rounded cos/sin of k*22.5 deg.
    for (int k = 0; k < 16; k++) begin
      check("rom_real", int'(dut.twiddle_rom_real[k]), cos_tab[k]);
      check("rom_imag", int'(dut.twiddle_rom_imag[k]), cos_tab[(k + 12) % 16]);
    end

    reset = 1'b1;

    // DC: running sum ramps by 10 then holds at 160 once the window is full.
    for (int i = 1; i <= 20; i++) begin
      step(10);
      check("dc_f0", obs_port(freqs_0), (i <= 16) ? 10 * i : 160);
    end

    // Alternating -10/+10: bin 0 cancels once the window is full, bin 8 holds 160.
    for (int i = 0; i < 40; i++) begin
      step((i % 2 == 0) ? -10 : 10);
      if (i >= 15) check("alt_f0", obs_port(freqs_0), 0);
    end
    v = int'(dut.frequency_bins_real[8]);
    check("alt_bin8_mag", (v < 0) ? -v : v, 160);
    check("alt_bin8_im", int'(dut.frequency_bins_imag[8]), 0);

    // One-cycle-per-bin cosine tone: zero mean over a full window.
    for (int i = 0; i < 32; i++) begin
      step(tone[i % 16]);
      if (i >= 15) check("tone_f0", obs_port(freqs_0), 0);
    end

    // Flush with zeros.
    for (int i = 0; i < 16; i++) step(0);
    check("flush_f0", obs_port(freqs_0), 0);

    // Impulse survives exactly 16 cycles then leaves on pointer wrap.
    for (int i = 0; i < 21; i++) begin
      step((i == 0) ? 50 : 0);
      check("impulse_f0", obs_port(freqs_0), (i < 16) ? 50 : 0);
    end

    // Mid-stream async reset between edges.
    for (int i = 0; i < 8; i++) step(10);
    check("pre_reset_f0", obs_port(freqs_0), 80);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_f0", obs_port(freqs_0), 0);
    check("async_reset_bin8", int'(dut.frequency_bins_real[8]), 0);
    @(posedge clk);
    #1;
    model_reset();
    check("async_hold_f1", obs_port(freqs_1), 0);
    reset = 1'b1;

    // Restart reproduces the DC ramp with no stale history.
    for (int i = 1; i <= 5; i++) begin
      step(10);
      check("restart_f0", obs_port(freqs_0), 10 * i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
